// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider bank.
package clk_div_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Config structs carry the divisor at a fixed maximum width so the type is
    // independent of CNT_W; channels with narrower counters zero-extend.
    localparam int unsigned MAX_CNT_W = 32;

    typedef struct packed {
        logic [MAX_CNT_W-1:0] div;
        logic                 mode;
    } ch_cfg_t;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned ch_idx_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Valid/ready configuration port of the divider bank.
interface clk_div_bank_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8
);
    import clk_div_pkg::*;

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);

    logic            valid;
    logic            ready;
    logic [CH_W-1:0] ch;
    logic [CNT_W-1:0] div;
    logic            mode;

    modport master (output valid, ch, div, mode, input ready);
    modport slave  (input valid, ch, div, mode, output ready);

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active and shadow config, pending flag and
// registered div_out/tick outputs. DEFAULT_DIV must fit in CNT_W bits and
// CNT_W must not exceed MAX_CNT_W.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned DEFAULT_DIV  = 1,
    parameter bit          DEFAULT_MODE = 1'b0
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_en,
    input  logic    i_sync,
    input  logic    i_wr,
    input  ch_cfg_t i_cfg,
    output logic    o_pend,
    output logic    o_div_out,
    output logic    o_tick
);

    localparam ch_cfg_t RST_CFG = '{div: MAX_CNT_W'(DEFAULT_DIV), mode: DEFAULT_MODE};

    logic [CNT_W-1:0] r_cnt;
    ch_cfg_t          r_act;
    ch_cfg_t          r_sh;
    logic             r_pend;
    logic             r_out;
    logic             r_tick;

    logic [CNT_W-1:0] w_cnt_d;
    ch_cfg_t          w_act_d;
    ch_cfg_t          w_sh_d;
    logic             w_pend_d;
    logic             w_out_d;
    logic             w_tick_d;
    logic             w_wrap;
    logic             w_apply;
    logic             w_mode_chg;

    // Next-state: sync/disable restart the channel, wrap closes a period, and
    // a pending shadow config is only ever promoted on one of those edges.
    always_comb begin
        w_cnt_d    = r_cnt;
        w_act_d    = r_act;
        w_sh_d     = r_sh;
        w_pend_d   = r_pend;
        w_out_d    = r_out;
        w_tick_d   = 1'b0;
        w_wrap     = (MAX_CNT_W'(r_cnt) == r_act.div);
        w_apply    = r_pend & (i_sync | ~i_en | w_wrap);
        w_mode_chg = w_apply & (r_sh.mode != r_act.mode);

        if (i_sync || !i_en) begin
            // Sync beats a same-cycle wrap: no tick is produced.
            w_cnt_d = '0;
            w_out_d = 1'b0;
        end else if (w_wrap) begin
            w_cnt_d  = '0;
            w_tick_d = 1'b1;
            if (w_mode_chg) begin
                w_out_d = 1'b0;
            end else if (r_act.mode == MODE_PULSE) begin
                w_out_d = 1'b1;
            end else begin
                w_out_d = ~r_out;
            end
        end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
            if (r_act.mode == MODE_PULSE) begin
                w_out_d = 1'b0;
            end
        end

        if (w_apply) begin
            w_act_d  = r_sh;
            w_pend_d = 1'b0;
        end

        // Ready is low while pending, so accept and apply never collide.
        if (i_wr) begin
            w_sh_d   = i_cfg;
            w_pend_d = 1'b1;
        end
    end

    // Channel state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_act  <= RST_CFG;
            r_sh   <= RST_CFG;
            r_pend <= 1'b0;
            r_out  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_d;
            r_act  <= w_act_d;
            r_sh   <= w_sh_d;
            r_pend <= w_pend_d;
            r_out  <= w_out_d;
            r_tick <= w_tick_d;
        end
    end

    assign o_pend    = r_pend;
    assign o_div_out = r_out;
    assign o_tick    = r_tick;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock-enable/divider bank. Outputs are
// registered strobes meant to be used as enables, never as clocks.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned DEFAULT_DIV  = 1,
    parameter bit          DEFAULT_MODE = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_en,
    input  logic              i_sync,
    clk_div_bank_if.slave     cfg,
    output logic [NUM_CH-1:0] o_div_out,
    output logic [NUM_CH-1:0] o_tick
);

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_wr;
    logic              w_ready;
    ch_cfg_t           w_cfg;

    // Ready mux: an out-of-range channel matches nothing and reads as ready,
    // so such writes complete and are dropped.
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.ch == CH_W'(i)) begin
                w_ready = ~w_pend[i];
            end
        end
    end

    // Write decode: one-hot strobe to the addressed channel on accept.
    always_comb begin
        w_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr[i] = cfg.valid & w_ready & (cfg.ch == CH_W'(i));
        end
    end

    assign cfg.ready = w_ready;
    assign w_cfg     = '{div: MAX_CNT_W'(cfg.div), mode: cfg.mode};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .CNT_W        (CNT_W),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .DEFAULT_MODE (DEFAULT_MODE)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_en      (i_en[g]),
            .i_sync    (i_sync),
            .i_wr      (w_wr[g]),
            .i_cfg     (w_cfg),
            .o_pend    (w_pend[g]),
            .o_div_out (o_div_out[g]),
            .o_tick    (o_tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed steps plus a randomized
// phase, checked against a per-channel period model.
module tb_clk_div_bank;

    localparam int NCH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync;
    logic [3:0] en;
    logic [3:0] div_out;
    logic [3:0] tick;
    logic [2:0] div_out3;
    logic [2:0] tick3;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per channel.
    int m_T[NCH];
    int m_sT[NCH];
    int m_pos[NCH];
    bit m_mode[NCH];
    bit m_smode[NCH];
    bit m_pend[NCH];
    bit m_out[NCH];
    bit m_tick[NCH];

    always #5 clk = ~clk;

    clk_div_bank_if #(.NUM_CH(4), .CNT_W(8)) u_if ();
    clk_div_bank_if #(.NUM_CH(3), .CNT_W(8)) u_if3 ();

    clk_div_bank #(
        .NUM_CH       (4),
        .CNT_W        (8),
        .DEFAULT_DIV  (1),
        .DEFAULT_MODE (1'b0)
    ) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_sync    (sync),
        .cfg       (u_if),
        .o_div_out (div_out),
        .o_tick    (tick)
    );

    clk_div_bank #(
        .NUM_CH       (3),
        .CNT_W        (8),
        .DEFAULT_DIV  (1),
        .DEFAULT_MODE (1'b0)
    ) u_dut3 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en[2:0]),
        .i_sync    (sync),
        .cfg       (u_if3),
        .o_div_out (div_out3),
        .o_tick    (tick3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready(input int ch);
        return (ch >= NCH) ? 1'b1 : !m_pend[ch];
    endfunction

    function automatic logic [3:0] out_vec();
        logic [3:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_out[i];
        return v;
    endfunction

    function automatic logic [3:0] tick_vec();
        logic [3:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_tick[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_T[i] = 1; m_mode[i] = 1'b0; m_sT[i] = 1; m_smode[i] = 1'b0;
            m_pend[i] = 1'b0; m_pos[i] = 0; m_out[i] = 1'b0; m_tick[i] = 1'b0;
        end
    endtask

    // One clock edge of the model: a period lasts T+1 cycles, ends in a tick,
    // and is the only place (besides sync/disable) a pending config lands.
    task automatic m_edge(input bit acc);
        for (int i = 0; i < NCH; i++) begin
            bit wrap;
            bit apply;
            bit chg;
            wrap  = (m_pos[i] == m_T[i]);
            apply = m_pend[i] && (sync || !en[i] || wrap);
            chg   = apply && (m_smode[i] != m_mode[i]);
            if (sync || !en[i]) begin
                m_pos[i] = 0; m_out[i] = 1'b0; m_tick[i] = 1'b0;
            end else if (wrap) begin
                m_pos[i]  = 0;
                m_tick[i] = 1'b1;
                if (chg) m_out[i] = 1'b0;
                else if (m_mode[i]) m_out[i] = 1'b1;
                else m_out[i] = !m_out[i];
            end else begin
                m_pos[i]  = m_pos[i] + 1;
                m_tick[i] = 1'b0;
                if (m_mode[i]) m_out[i] = 1'b0;
            end
            if (apply) begin
                m_T[i] = m_sT[i]; m_mode[i] = m_smode[i]; m_pend[i] = 1'b0;
            end
            if (acc && int'(u_if.ch) == i) begin
                m_sT[i] = int'(u_if.div); m_smode[i] = u_if.mode; m_pend[i] = 1'b1;
            end
        end
    endtask

    // Check ready before the edge, advance model on the edge, check outputs after.
    task automatic cycle();
        bit acc;
        #1;
        chk("cfg_ready", 32'(u_if.ready), 32'(m_ready(int'(u_if.ch))));
        acc = u_if.valid && m_ready(int'(u_if.ch));
        @(posedge clk);
        m_edge(acc);
        #1;
        chk("div_out", 32'(div_out), 32'(out_vec()));
        chk("tick", 32'(tick), 32'(tick_vec()));
    endtask

    task automatic cfg_write(input int ch, input int div, input bit mode);
        int guard;
        guard = 0;
        u_if.valid = 1'b0;
        u_if.ch    = 2'(ch);
        u_if.div   = 8'(div);
        u_if.mode  = mode;
        while (!m_ready(ch) && guard < 400) begin
            cycle();
            guard++;
        end
        chk("cfg_wait_bound", 32'(guard < 400), 32'd1);
        u_if.valid = 1'b1;
        cycle();
        u_if.valid = 1'b0;
    endtask

    initial begin
        int cnt;
        int last;
        int prev;

        rst_n = 1'b0; en = 4'hF; sync = 1'b0;
        u_if.valid = 1'b0; u_if.ch = '0; u_if.div = '0; u_if.mode = 1'b0;
        u_if3.valid = 1'b0; u_if3.ch = '0; u_if3.div = '0; u_if3.mode = 1'b0;
        m_reset();

        // Reset defaults, then T=1 toggle on every channel.
        #12;
        chk("rst_div_out", 32'(div_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (k >= 4 && tick[0]) cnt++;
        end
        chk("tick_rate_t1", 32'(cnt), 32'd4);

        // Reconfigure ch2 to T=4 pulse mode mid-period.
        cycle();
        cfg_write(2, 4, 1'b1);
        u_if.ch = 2'd2;
        last = -100; prev = -100;
        for (int k = 0; k < 25; k++) begin
            cycle();
            if (div_out[2]) begin prev = last; last = k; end
        end
        chk("pulse_period_t4", 32'(last - prev), 32'd5);

        // Corner values: T=0 toggle, T=0 pulse, T=255.
        cfg_write(0, 0, 1'b0);
        cfg_write(1, 0, 1'b1);
        cfg_write(3, 255, 1'b0);
        last = -1000; prev = -1000;
        for (int k = 0; k < 600; k++) begin
            cycle();
            if (tick[3]) begin prev = last; last = k; end
        end
        chk("tick_period_t255", 32'(last - prev), 32'd256);

        // Sync with channels at different phases (ch0 wraps on every edge).
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        chk("sync_out_clear", 32'(div_out), 32'd0);
        chk("sync_no_tick", 32'(tick), 32'd0);
        for (int k = 0; k < 20; k++) cycle();

        // Disable with a pending config, then re-enable.
        cfg_write(1, 200, 1'b0);
        cfg_write(1, 9, 1'b0);
        u_if.ch = 2'd1;
        for (int k = 0; k < 3; k++) cycle();
        en[1] = 1'b0;
        cycle();
        chk("dis_out1", 32'(div_out[1]), 32'd0);
        cycle();
        en[1] = 1'b1;
        cnt = 0;
        do begin
            cycle();
            cnt++;
        end while (!tick[1] && cnt < 40);
        chk("reen_first_tick", 32'(cnt), 32'd10);

        // Randomized enables, syncs and config writes.
        for (int k = 0; k < 300; k++) begin
            en         = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
            sync       = ($urandom_range(0, 24) == 0);
            u_if.valid = ($urandom_range(0, 3) == 0);
            u_if.ch    = 2'($urandom);
            u_if.div   = 8'($urandom_range(0, 12));
            u_if.mode  = 1'($urandom);
            cycle();
        end
        en = 4'hF; sync = 1'b0; u_if.valid = 1'b0;
        for (int k = 0; k < 10; k++) cycle();

        // Async reset mid-run with a config still pending on ch3.
        cfg_write(3, 200, 1'b1);
        cfg_write(3, 50, 1'b0);
        u_if.ch = 2'd3;
        for (int k = 0; k < 3; k++) cycle();
        #3;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("arst_div_out", 32'(div_out), 32'd0);
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_pend_clr", 32'(u_if.ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Out-of-range channel write on the 3-channel instance is dropped.
        u_if3.ch = 2'd3; u_if3.div = 8'd0; u_if3.mode = 1'b1; u_if3.valid = 1'b1;
        #1;
        chk("oor_ready", 32'(u_if3.ready), 32'd1);
        for (int k = 0; k < 12; k++) begin
            cycle();
            chk("oor_div_out", 32'(div_out3), 32'(out_vec() & 4'h7));
            chk("oor_tick", 32'(tick3), 32'(tick_vec() & 4'h7));
        end
        u_if3.valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
